// File: rtl/pixel_raycaster_if.sv
// Voxel broadcast stream: one beat per voxel (integer coordinates + palette id).
// Valid/ready handshake; a beat transfers on a clock where voxel_valid && voxel_ready.
// master = voxel source, slave = raycaster instance.
interface pixel_raycaster_if #(
   parameter int COORD_BITS   = 8,
   parameter int PALETTE_BITS = 8
);
   logic                    voxel_valid;
   logic                    voxel_ready;
   logic [COORD_BITS-1:0]   voxel_x;
   logic [COORD_BITS-1:0]   voxel_y;
   logic [COORD_BITS-1:0]   voxel_z;
   logic [PALETTE_BITS-1:0] voxel_id;

   modport master (output voxel_valid, voxel_x, voxel_y, voxel_z, voxel_id,
                   input  voxel_ready);
   modport slave  (input  voxel_valid, voxel_x, voxel_y, voxel_z, voxel_id,
                   output voxel_ready);
endinterface

// File: rtl/pixel_raycaster.sv
// Per-pixel ray/voxel slab-test engine keeping the nearest hit depth and palette id.
// Latency: accept to raster_done = 6*(TW-1)+2 cycles; one voxel per latency+1 cycles.
// Backpressure: voxel_ready low while a voxel is in flight or during frame_start.
// Ports: clock/reset (async, active-high), frame_start clears the stored hit, vox carries
// voxels, cam_pos_* (unsigned C.F) / ray_dir_* (signed) are sampled on accept, row/col
// select readout onto pixel/pixel_hit (zero when not selected), raster_done/busy status.
module pixel_raycaster #(
   parameter int ROW          = 0,
   parameter int COL          = 0,
   parameter int ROW_BITS     = 8,
   parameter int COL_BITS     = 8,
   parameter int COORD_BITS   = 8,
   parameter int FRAC_BITS    = 8,
   parameter int PALETTE_BITS = 8
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               frame_start,
   pixel_raycaster_if.slave                   vox,
   input  logic [COORD_BITS+FRAC_BITS-1:0]    cam_pos_x,
   input  logic [COORD_BITS+FRAC_BITS-1:0]    cam_pos_y,
   input  logic [COORD_BITS+FRAC_BITS-1:0]    cam_pos_z,
   input  logic [COORD_BITS+FRAC_BITS-1:0]    ray_dir_x,
   input  logic [COORD_BITS+FRAC_BITS-1:0]    ray_dir_y,
   input  logic [COORD_BITS+FRAC_BITS-1:0]    ray_dir_z,
   input  logic [ROW_BITS-1:0]                row,
   input  logic [COL_BITS-1:0]                col,
   output logic                               raster_done,
   output logic                               busy,
   output logic [PALETTE_BITS-1:0]            pixel,
   output logic                               pixel_hit
);
   localparam int C  = COORD_BITS;
   localparam int F  = FRAC_BITS;
   localparam int W  = C + F;
   localparam int TW = W + F + 2;
   localparam int CW = $clog2(TW - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DIVIDE  = 2'd1;
   localparam logic [1:0] S_COMPARE = 2'd2;
   localparam logic [1:0] S_UPDATE  = 2'd3;

   localparam logic signed [TW-1:0] NEG_INF  = {1'b1, {(TW-1){1'b0}}};
   localparam logic signed [TW-1:0] POS_INF  = {1'b0, {(TW-1){1'b1}}};
   localparam logic [CW-1:0]        LAST_BIT = CW'(TW - 2);

   logic [1:0]              state;
   logic [C-1:0]            v_q [0:2];
   logic [W-1:0]            p_q [0:2];
   logic [W-1:0]            d_q [0:2];
   logic [PALETTE_BITS-1:0] vid_q;
   logic [2:0]              div_idx;
   logic [CW-1:0]           bit_cnt;
   logic [W-1:0]            rem_q;
   logic [TW-3:0]           q_q;
   logic signed [TW-1:0]    t_q [0:5];
   logic                    hit_q;
   logic [TW-1:0]           dnew_q;
   logic [TW-1:0]           depth_q;
   logic [PALETTE_BITS-1:0] id_q;

   // ---------------- serial restoring divider ----------------
   // div_idx: {axis, slab side}; side 0 uses v, side 1 uses v+1 (one bit wider, no wrap).
   logic [1:0]           axis;
   logic [C-1:0]         v_cur;
   logic [W-1:0]         p_cur;
   logic [W-1:0]         d_cur;
   logic [C:0]           v_edge;
   logic signed [W+1:0]  n_cur;
   logic                 n_neg;
   logic [W:0]           n_mag;
   logic [TW-2:0]        dividend;
   logic                 d_neg;
   logic [W-1:0]         d_mag;
   logic                 div_bit;
   logic [W-1:0]         rem_base;
   logic [W:0]           rem_sh;
   logic                 q_ge;
   logic [W-1:0]         rem_nx;
   logic [TW-2:0]        q_nx;
   logic signed [TW-1:0] q_signed;

   assign axis     = div_idx[2:1];
   assign v_cur    = v_q[axis];
   assign p_cur    = p_q[axis];
   assign d_cur    = d_q[axis];
   assign v_edge   = div_idx[0] ? ({1'b0, v_cur} + 1'b1) : {1'b0, v_cur};
   assign n_cur    = {1'b0, v_edge, {F{1'b0}}} - {2'b00, p_cur};
   assign n_neg    = n_cur[W+1];
   assign n_mag    = (W+1)'(n_neg ? -n_cur : n_cur);
   assign dividend = {n_mag, {F{1'b0}}};
   assign d_neg    = d_cur[W-1];
   assign d_mag    = d_neg ? -d_cur : d_cur;
   assign div_bit  = dividend[LAST_BIT - bit_cnt];
   assign rem_base = (bit_cnt == '0) ? '0 : rem_q;
   assign rem_sh   = {rem_base, div_bit};
   assign q_ge     = rem_sh >= {1'b0, d_mag};
   // When q_ge the true difference is below |d|, so a W-bit subtraction is exact.
   assign rem_nx   = q_ge ? (rem_sh[W-1:0] - d_mag) : rem_sh[W-1:0];
   assign q_nx     = {q_q, q_ge};
   assign q_signed = (n_neg ^ d_neg) ? -$signed({1'b0, q_nx}) : $signed({1'b0, q_nx});

   // ---------------- slab combine ----------------
   logic signed [TW-1:0] enter_c;
   logic signed [TW-1:0] exit_c;
   logic                 axes_ok;
   logic                 hit_c;
   logic [TW-1:0]        dnew_c;

   always_comb begin
      logic signed [TW-1:0] near_v;
      logic signed [TW-1:0] far_v;
      enter_c = NEG_INF;
      exit_c  = POS_INF;
      axes_ok = 1'b1;
      near_v  = NEG_INF;
      far_v   = POS_INF;
      for (int a = 0; a < 3; a++) begin
         if (d_q[a] == '0) begin
            // Ray parallel to this slab: it either lies inside for all t or never enters.
            if (!((p_q[a] >= {v_q[a], {F{1'b0}}}) &&
                  ({1'b0, p_q[a]} < {({1'b0, v_q[a]} + 1'b1), {F{1'b0}}})))
               axes_ok = 1'b0;
         end else begin
            near_v = (t_q[2*a] < t_q[2*a+1]) ? t_q[2*a] : t_q[2*a+1];
            far_v  = (t_q[2*a] < t_q[2*a+1]) ? t_q[2*a+1] : t_q[2*a];
            if (near_v > enter_c) enter_c = near_v;
            if (far_v < exit_c)   exit_c  = far_v;
         end
      end
      hit_c  = axes_ok && (enter_c <= exit_c) && !exit_c[TW-1] && (vid_q != '0);
      dnew_c = enter_c[TW-1] ? '0 : enter_c;
   end

   // ---------------- control / state ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         vid_q   <= '0;
         div_idx <= '0;
         bit_cnt <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         hit_q   <= 1'b0;
         dnew_q  <= '0;
         depth_q <= '1;
         id_q    <= '0;
         for (int i = 0; i < 3; i++) begin
            v_q[i] <= '0;
            p_q[i] <= '0;
            d_q[i] <= '0;
         end
         for (int i = 0; i < 6; i++) t_q[i] <= '0;
      end else if (frame_start) begin
         state   <= S_IDLE;
         depth_q <= '1;
         id_q    <= '0;
         div_idx <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (vox.voxel_valid) begin
                  v_q[0]  <= vox.voxel_x;
                  v_q[1]  <= vox.voxel_y;
                  v_q[2]  <= vox.voxel_z;
                  vid_q   <= vox.voxel_id;
                  p_q[0]  <= cam_pos_x;
                  p_q[1]  <= cam_pos_y;
                  p_q[2]  <= cam_pos_z;
                  d_q[0]  <= ray_dir_x;
                  d_q[1]  <= ray_dir_y;
                  d_q[2]  <= ray_dir_z;
                  div_idx <= '0;
                  bit_cnt <= '0;
                  state   <= S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               rem_q <= rem_nx;
               q_q   <= q_nx[TW-3:0];
               if (bit_cnt == LAST_BIT) begin
                  t_q[div_idx] <= q_signed;
                  bit_cnt      <= '0;
                  if (div_idx == 3'd5) state <= S_COMPARE;
                  else                 div_idx <= div_idx + 3'd1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_COMPARE: begin
               hit_q  <= hit_c;
               dnew_q <= dnew_c;
               state  <= S_UPDATE;
            end
            S_UPDATE: begin
               // Strictly nearer only: on a tie the earlier voxel stays.
               if (hit_q && (dnew_q < depth_q)) begin
                  depth_q <= dnew_q;
                  id_q    <= vid_q;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------- status and readout ----------------
   logic sel;

   assign busy            = (state != S_IDLE);
   assign vox.voxel_ready = !busy && !frame_start;
   assign raster_done     = (state == S_UPDATE);
   assign sel             = (row == ROW_BITS'(ROW)) && (col == COL_BITS'(COL));
   assign pixel           = sel ? id_q : '0;
   assign pixel_hit       = sel && (id_q != '0);
endmodule

// File: tb/tb_pixel_raycaster.sv
// Bench for pixel_raycaster: directed spec scenarios plus randomized voxels/cameras,
// compared against a plain-arithmetic slab-test model of the nearest hit.
module tb_pixel_raycaster;
   localparam int ROW = 2;
   localparam int COL = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        frame_start;
   logic [15:0] cam_x, cam_y, cam_z;
   logic [15:0] dir_x, dir_y, dir_z;
   logic [7:0]  row, col;
   logic        raster_done, busy, pixel_hit;
   logic [7:0]  pixel;

   int     checks   = 0;
   int     failures = 0;
   longint m_depth;
   int     m_id;

   always #5 clock = ~clock;

   pixel_raycaster_if #(.COORD_BITS(8), .PALETTE_BITS(8)) vox ();

   pixel_raycaster #(
      .ROW(ROW), .COL(COL), .ROW_BITS(8), .COL_BITS(8),
      .COORD_BITS(8), .FRAC_BITS(8), .PALETTE_BITS(8)
   ) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .vox(vox),
      .cam_pos_x(cam_x), .cam_pos_y(cam_y), .cam_pos_z(cam_z),
      .ray_dir_x(dir_x), .ray_dir_y(dir_y), .ray_dir_z(dir_z),
      .row(row), .col(col), .raster_done(raster_done), .busy(busy),
      .pixel(pixel), .pixel_hit(pixel_hit)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Signed fixed-point slab distance: |n|*2^F / |d| truncated, sign applied afterwards.
   function automatic longint tdiv(input longint n, input longint d);
      longint q;
      q = ((n < 0 ? -n : n) * 256) / (d < 0 ? -d : d);
      return ((n < 0) != (d < 0)) ? -q : q;
   endfunction

   task automatic model_voxel(input int vx, input int vy, input int vz, input int vid);
      longint v[3], p[3], d[3];
      longint enter, exitv, ta, tb, dn;
      bit ok, hit;
      v[0] = vx; v[1] = vy; v[2] = vz;
      p[0] = longint'(cam_x); p[1] = longint'(cam_y); p[2] = longint'(cam_z);
      d[0] = longint'($signed(dir_x)); d[1] = longint'($signed(dir_y)); d[2] = longint'($signed(dir_z));
      enter = -(longint'(1) << 40);
      exitv = longint'(1) << 40;
      ok = 1'b1;
      for (int a = 0; a < 3; a++) begin
         if (d[a] == 0) begin
            if (!(p[a] >= v[a] * 256 && p[a] < (v[a] + 1) * 256)) ok = 1'b0;
         end else begin
            ta = tdiv(v[a] * 256 - p[a], d[a]);
            tb = tdiv((v[a] + 1) * 256 - p[a], d[a]);
            if ((ta < tb ? ta : tb) > enter) enter = (ta < tb ? ta : tb);
            if ((ta < tb ? tb : ta) < exitv) exitv = (ta < tb ? tb : ta);
         end
      end
      hit = ok && (enter <= exitv) && (exitv >= 0) && (vid != 0);
      dn  = (enter < 0) ? 0 : enter;
      if (hit && dn < m_depth) begin
         m_depth = dn;
         m_id    = vid;
      end
   endtask

   task automatic model_clear();
      m_depth = (longint'(1) << 26) - 1;
      m_id    = 0;
   endtask

   task automatic drive_voxel(input int vx, input int vy, input int vz, input int vid);
      vox.voxel_x  = 8'(vx);
      vox.voxel_y  = 8'(vy);
      vox.voxel_z  = 8'(vz);
      vox.voxel_id = 8'(vid);
   endtask

   // Called just after a rising edge; returns just after the edge that ends UPDATE.
   task automatic run_voxel(input int vx, input int vy, input int vz, input int vid, input string tag);
      int lat, w;
      bit done;
      drive_voxel(vx, vy, vz, vid);
      vox.voxel_valid = 1'b1;
      w = 0;
      @(negedge clock);
      while (!vox.voxel_ready && w < 400) begin
         @(negedge clock);
         w++;
      end
      @(posedge clock);
      #1 vox.voxel_valid = 1'b0;
      lat = 0;
      done = 1'b0;
      while (!done && lat < 400) begin
         @(negedge clock);
         lat++;
         if (raster_done) done = 1'b1;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd152);
      @(posedge clock);
      #1;
      model_voxel(vx, vy, vz, vid);
      chk({tag, "_pixel"}, 64'(pixel), 64'(m_id));
      chk({tag, "_pixel_hit"}, 64'(pixel_hit), 64'(m_id != 0));
   endtask

   task automatic pulse_frame(input string tag);
      frame_start = 1'b1;
      #1 chk({tag, "_ready_during_fs"}, 64'(vox.voxel_ready), 64'd0);
      @(posedge clock);
      #1 frame_start = 1'b0;
      model_clear();
      chk({tag, "_pixel_after_fs"}, 64'(pixel), 64'd0);
      chk({tag, "_busy_after_fs"}, 64'(busy), 64'd0);
   endtask

   task automatic set_defaults();
      cam_x = 16'h0080; cam_y = 16'h0080; cam_z = 16'h0000;
      dir_x = 16'h0000; dir_y = 16'h0000; dir_z = 16'h0100;
   endtask

   function automatic logic [15:0] rand_dir();
      int mag;
      if ($urandom_range(0, 3) == 0) return 16'h0000;
      mag = int'($urandom_range(1, 16'h0300));
      return ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
   endfunction

   initial begin
      int acc, dn_cnt, n_done, vx, vy, vz, vid;
      reset = 1'b1;
      frame_start = 1'b0;
      vox.voxel_valid = 1'b0;
      drive_voxel(0, 0, 0, 0);
      row = 8'(ROW);
      col = 8'(COL);
      set_defaults();
      model_clear();
      #2;
      chk("reset_ready", 64'(vox.voxel_ready), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(raster_done), 64'd0);
      chk("reset_pixel", 64'(pixel), 64'd0);
      chk("reset_hit", 64'(pixel_hit), 64'd0);
      repeat (3) @(posedge clock);
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      #1;

      // First hit, then nearer, tie, and x-axis miss.
      run_voxel(0, 0, 3, 5, "t1");
      chk("t1_pixel_const", 64'(pixel), 64'd5);
      run_voxel(0, 0, 2, 7, "t2a");
      chk("t2a_pixel_const", 64'(pixel), 64'd7);
      run_voxel(0, 0, 2, 8, "t2_tie");
      chk("t2_tie_const", 64'(pixel), 64'd7);
      run_voxel(1, 0, 1, 9, "t2_xmiss");
      chk("t2_xmiss_const", 64'(pixel), 64'd7);
      row = 8'(ROW + 1);
      #1 chk("t2_rowsel_pixel", 64'(pixel), 64'd0);
      chk("t2_rowsel_hit", 64'(pixel_hit), 64'd0);
      row = 8'(ROW);
      col = 8'(COL + 1);
      #1 chk("t2_colsel_pixel", 64'(pixel), 64'd0);
      col = 8'(COL);
      #1 chk("t2_sel_back", 64'(pixel), 64'd7);

      // Camera behind the voxel: forward ray misses, reversed ray hits at depth 2.0.
      @(posedge clock);
      #1 pulse_frame("fs1");
      cam_z = 16'h0500;
      run_voxel(0, 0, 2, 4, "t3_behind");
      chk("t3_behind_const", 64'(pixel), 64'd0);
      dir_z = 16'hFF00;
      run_voxel(0, 0, 2, 4, "t3_reverse");
      chk("t3_reverse_const", 64'(pixel), 64'd4);

      // Air voxel never updates; frame_start clears a stored hit.
      set_defaults();
      run_voxel(0, 0, 1, 0, "t4_air");
      chk("t4_air_const", 64'(pixel), 64'd4);
      pulse_frame("fs2");

      // frame_start in the middle of DIVIDE discards the voxel.
      run_voxel(0, 0, 3, 5, "t5_pre");
      drive_voxel(0, 0, 1, 6);
      vox.voxel_valid = 1'b1;
      @(posedge clock);
      #1 vox.voxel_valid = 1'b0;
      repeat (40) @(negedge clock);
      chk("t5_busy_mid", 64'(busy), 64'd1);
      pulse_frame("t5_abort");
      n_done = 0;
      repeat (200) begin
         @(negedge clock);
         if (raster_done) n_done++;
      end
      chk("t5_no_done", 64'(n_done), 64'd0);
      chk("t5_pixel_cleared", 64'(pixel), 64'd0);

      // Asynchronous reset in the middle of DIVIDE.
      @(posedge clock);
      #1 run_voxel(0, 0, 3, 5, "t5r_pre");
      drive_voxel(0, 0, 1, 6);
      vox.voxel_valid = 1'b1;
      @(posedge clock);
      #1 vox.voxel_valid = 1'b0;
      repeat (40) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      model_clear();
      chk("t5r_ready", 64'(vox.voxel_ready), 64'd1);
      chk("t5r_busy", 64'(busy), 64'd0);
      chk("t5r_done", 64'(raster_done), 64'd0);
      chk("t5r_pixel", 64'(pixel), 64'd0);
      chk("t5r_hit", 64'(pixel_hit), 64'd0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      #1;

      // voxel_valid held high: accepts only in IDLE, one raster_done per accept.
      drive_voxel(0, 0, 4, 11);
      vox.voxel_valid = 1'b1;
      acc = 0;
      dn_cnt = 0;
      repeat (459) begin
         @(negedge clock);
         if (vox.voxel_valid && vox.voxel_ready) begin
            acc++;
            model_voxel(0, 0, 4, 11);
         end
         if (raster_done) dn_cnt++;
      end
      vox.voxel_valid = 1'b0;
      chk("t6_accepts", 64'(acc), 64'd3);
      chk("t6_dones", 64'(dn_cnt), 64'(acc));
      @(posedge clock);
      #1 chk("t6_pixel", 64'(pixel), 64'(m_id));

      // Randomized cameras, rays and voxels against the model.
      for (int i = 0; i < 16; i++) begin
         if (i % 6 == 5) pulse_frame("rnd_fs");
         cam_x = 16'($urandom_range(0, 16'h03FF));
         cam_y = 16'($urandom_range(0, 16'h03FF));
         cam_z = 16'($urandom_range(0, 16'h03FF));
         dir_x = rand_dir();
         dir_y = rand_dir();
         dir_z = rand_dir();
         vx  = int'($urandom_range(0, 3));
         vy  = int'($urandom_range(0, 3));
         vz  = int'($urandom_range(0, 3));
         vid = int'($urandom_range(0, 15));
         run_voxel(vx, vy, vz, vid, "rnd");
         row = 8'($urandom_range(0, 4));
         col = 8'($urandom_range(1, 4));
         #1 chk("rnd_select", 64'(pixel), 64'((row == 8'(ROW) && col == 8'(COL)) ? m_id : 0));
         row = 8'(ROW);
         col = 8'(COL);
         @(posedge clock);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
